free_bitmap_manager_3w: RTL and testbench

//  Owns the 64-entry free bitmap that the triple LSB-priority allocator scans each cycle.

---
 rtl/free_bitmap_manager_3w.sv | 123 ++++++++++++
 tb/tb_free_bitmap_manager_3w.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/free_bitmap_manager_3w.sv
// Free-list bitmap for the 3-wide rename allocator: applies up to 3 grants (clears)
// and 3 releases (sets) per cycle, or a flush reload, and tracks count/low-water/errors.
module free_bitmap_manager_3w #(
  parameter int                 WIDTH           = 64,
  parameter int                 INDEX_WIDTH     = 6,
  parameter int                 COUNT_WIDTH     = 7,
  parameter logic [WIDTH-1:0]   RESET_FREE_MASK = 64'hFFFF_FFFF_0000_0000,
  parameter int                 LOW_WATER       = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  alloc_valid,
  input  logic [2:0][INDEX_WIDTH-1:0] alloc_index,
  input  logic [2:0]                  release_valid,
  input  logic [2:0][INDEX_WIDTH-1:0] release_index,
  input  logic                        flush_valid,
  input  logic [WIDTH-1:0]            flush_free_mask,
  output logic [WIDTH-1:0]            free_bitmap,
  output logic [COUNT_WIDTH-1:0]      free_count,
  output logic                        almost_empty,
  output logic                        double_free_err,
  output logic                        alloc_busy_err
);

  localparam logic [WIDTH-1:0]       ONE_HOT_BASE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] RESET_COUNT  = COUNT_WIDTH'($countones(RESET_FREE_MASK));
  localparam logic [COUNT_WIDTH-1:0] LOW_WATER_C  = COUNT_WIDTH'(LOW_WATER);

  logic [WIDTH-1:0]       bitmap_q, bitmap_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   almost_empty_q, almost_empty_d;
  logic                   dfe_q, dfe_d;
  logic                   abe_q, abe_d;

  logic [2:0][WIDTH-1:0]  alloc_onehot;
  logic [2:0][WIDTH-1:0]  rel_onehot;
  logic [2:0]             alloc_hits_busy;
  logic [2:0]             rel_hits_free;
  logic [2:0]             alloc_dup;
  logic [2:0]             rel_dup;
  logic [WIDTH-1:0]       alloc_clr;
  logic [WIDTH-1:0]       rel_set;

  function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [COUNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + COUNT_WIDTH'(v[i]);
    end
    return c;
  endfunction

  // Per-port decode and legality checks against the current registered bitmap.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_port
      assign alloc_onehot[gi]    = alloc_valid[gi]   ? (ONE_HOT_BASE << alloc_index[gi])   : '0;
      assign rel_onehot[gi]      = release_valid[gi] ? (ONE_HOT_BASE << release_index[gi]) : '0;
      assign alloc_hits_busy[gi] = alloc_valid[gi]   & ~bitmap_q[alloc_index[gi]];
      assign rel_hits_free[gi]   = release_valid[gi] &  bitmap_q[release_index[gi]];
    end
  endgenerate

  // A port is a duplicate if any lower-numbered valid port carries the same index.
  always_comb begin
    alloc_dup = '0;
    rel_dup   = '0;
    for (int k = 1; k < 3; k++) begin
      for (int j = 0; j < k; j++) begin
        if (alloc_valid[k] && alloc_valid[j] && (alloc_index[k] == alloc_index[j])) begin
          alloc_dup[k] = 1'b1;
        end
        if (release_valid[k] && release_valid[j] && (release_index[k] == release_index[j])) begin
          rel_dup[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    alloc_clr = alloc_onehot[0] | alloc_onehot[1] | alloc_onehot[2];
    rel_set   = rel_onehot[0]   | rel_onehot[1]   | rel_onehot[2];

    bitmap_d = bitmap_q;
    dfe_d    = dfe_q;
    abe_d    = abe_q;

    if (flush_valid) begin
      bitmap_d = flush_free_mask;
    end else begin
      // Allocation wins over a release landing on the same bit.
      bitmap_d = (bitmap_q & ~alloc_clr) | (rel_set & ~alloc_clr);
      dfe_d    = dfe_q | (|rel_hits_free) | (|rel_dup);
      abe_d    = abe_q | (|alloc_hits_busy) | (|alloc_dup);
    end

    // Count is a fresh popcount of the next bitmap, so it can never drift or wrap.
    count_d        = popcount(bitmap_d);
    almost_empty_d = (count_d < LOW_WATER_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bitmap_q       <= RESET_FREE_MASK;
      count_q        <= RESET_COUNT;
      almost_empty_q <= (RESET_COUNT < LOW_WATER_C);
      dfe_q          <= 1'b0;
      abe_q          <= 1'b0;
    end else begin
      bitmap_q       <= bitmap_d;
      count_q        <= count_d;
      almost_empty_q <= almost_empty_d;
      dfe_q          <= dfe_d;
      abe_q          <= abe_d;
    end
  end

  assign free_bitmap     = bitmap_q;
  assign free_count      = count_q;
  assign almost_empty    = almost_empty_q;
  assign double_free_err = dfe_q;
  assign alloc_busy_err  = abe_q;

endmodule

// File: tb/tb_free_bitmap_manager_3w.sv
// Bench for free_bitmap_manager_3w: set-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_free_bitmap_manager_3w;

  localparam logic [63:0] RESET_MASK = 64'hFFFF_FFFF_0000_0000;

  logic            clk;
  logic            reset;
  logic [2:0]      alloc_valid;
  logic [2:0][5:0] alloc_index;
  logic [2:0]      release_valid;
  logic [2:0][5:0] release_index;
  logic            flush_valid;
  logic [63:0]     flush_free_mask;
  logic [63:0]     free_bitmap;
  logic [6:0]      free_count;
  logic            almost_empty;
  logic            double_free_err;
  logic            alloc_busy_err;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 0;

  free_bitmap_manager_3w dut (
    .clk             (clk),
    .reset           (reset),
    .alloc_valid     (alloc_valid),
    .alloc_index     (alloc_index),
    .release_valid   (release_valid),
    .release_index   (release_index),
    .flush_valid     (flush_valid),
    .flush_free_mask (flush_free_mask),
    .free_bitmap     (free_bitmap),
    .free_count      (free_count),
    .almost_empty    (almost_empty),
    .double_free_err (double_free_err),
    .alloc_busy_err  (alloc_busy_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the bitmap is treated as a set of free entries.
  typedef struct packed {
    logic [63:0] bm;
    logic        dfe;
    logic        abe;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(input mstate_t s, input logic rst,
                                         input logic [2:0] av, input logic [2:0][5:0] ai,
                                         input logic [2:0] rv, input logic [2:0][5:0] ri,
                                         input logic fl, input logic [63:0] fm);
    mstate_t r;
    bit      released[64];
    bit      taken[64];
    r = s;
    foreach (released[e]) begin
      released[e] = 0;
      taken[e]    = 0;
    end
    if (rst) begin
      r.bm  = RESET_MASK;
      r.dfe = 1'b0;
      r.abe = 1'b0;
      return r;
    end
    if (fl) begin
      r.bm = fm;
      return r;
    end
    for (int k = 0; k < 3; k++) begin
      if (rv[k]) begin
        if (s.bm[ri[k]] || released[ri[k]]) r.dfe = 1'b1;
        released[ri[k]] = 1;
      end
      if (av[k]) begin
        if (!s.bm[ai[k]] || taken[ai[k]]) r.abe = 1'b1;
        taken[ai[k]] = 1;
      end
    end
    for (int e = 0; e < 64; e++) begin
      r.bm[e] = (s.bm[e] || released[e]) && !taken[e];
    end
    return r;
  endfunction

  function automatic int count_free(input logic [63:0] v);
    int c = 0;
    for (int e = 0; e < 64; e++) if (v[e]) c++;
    return c;
  endfunction

  always @(posedge clk) begin
    m <= model_step(m, reset, alloc_valid, alloc_index, release_valid, release_index,
                    flush_valid, flush_free_mask);
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int c;
      c = count_free(m.bm);
      n_vec += 5;
      if (free_bitmap !== m.bm) begin
        n_miss++;
        $display("FAIL model_bitmap t=%0t got=%h exp=%h", $time, free_bitmap, m.bm);
      end
      if (free_count !== 7'(c)) begin
        n_miss++;
        $display("FAIL model_count t=%0t got=%0d exp=%0d", $time, free_count, c);
      end
      if (almost_empty !== (c < 3)) begin
        n_miss++;
        $display("FAIL model_almost_empty t=%0t got=%b exp=%b", $time, almost_empty, (c < 3));
      end
      if (double_free_err !== m.dfe) begin
        n_miss++;
        $display("FAIL model_dfe t=%0t got=%b exp=%b", $time, double_free_err, m.dfe);
      end
      if (alloc_busy_err !== m.abe) begin
        n_miss++;
        $display("FAIL model_abe t=%0t got=%b exp=%b", $time, alloc_busy_err, m.abe);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset           = 1'b0;
    alloc_valid     = '0;
    alloc_index     = '0;
    release_valid   = '0;
    release_index   = '0;
    flush_valid     = 1'b0;
    flush_free_mask = '0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("vec %s ok value=%h", name, got);
    end
  endtask

  task automatic chk_all(input string name, input logic [63:0] bm, input int cnt,
                         input logic ae, input logic dfe, input logic abe);
    chk({name, "_bitmap"}, free_bitmap, bm);
    chk({name, "_count"}, 64'(free_count), 64'(cnt));
    chk({name, "_ae"}, 64'(almost_empty), 64'(ae));
    chk({name, "_dfe"}, 64'(double_free_err), 64'(dfe));
    chk({name, "_abe"}, 64'(alloc_busy_err), 64'(abe));
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cyc();
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cyc();
    chk_en = 1;
    cyc();
    idle();
    // T1: reset values
    chk_all("t1_reset", 64'hFFFFFFFF_00000000, 32, 0, 0, 0);

    // T2: triple alloc
    alloc_valid = 3'b111;
    alloc_index = {6'd34, 6'd33, 6'd32};
    cyc(); idle();
    chk_all("t2_alloc3", 64'hFFFFFFF8_00000000, 29, 0, 0, 0);

    // T3: triple release from reset state
    do_reset();
    release_valid = 3'b111;
    release_index = {6'd7, 6'd6, 6'd5};
    cyc(); idle();
    chk_all("t3_rel3", 64'hFFFFFFFF_000000E0, 35, 0, 0, 0);

    // T4a: release already-free 40
    release_valid = 3'b001;
    release_index[0] = 6'd40;
    cyc(); idle();
    chk_all("t4_dfree40", 64'hFFFFFFFF_000000E0, 35, 0, 1, 0);

    // T4b: alloc and release 41 in the same cycle
    alloc_valid = 3'b001;   alloc_index[0] = 6'd41;
    release_valid = 3'b010; release_index[1] = 6'd41;
    cyc(); idle();
    chk_all("t4_same41", 64'hFFFFFDFF_000000E0, 34, 0, 1, 0);

    // T4c: release 9 on all three ports from a clean reset
    do_reset();
    release_valid = 3'b111;
    release_index = {6'd9, 6'd9, 6'd9};
    cyc(); idle();
    chk_all("t4_rel999", 64'hFFFFFFFF_00000200, 33, 0, 1, 0);

    // T5: flush dominates alloc/release and raises no errors
    do_reset();
    flush_valid = 1'b1; flush_free_mask = 64'h3;
    alloc_valid = 3'b001;   alloc_index[0] = 6'd0;
    release_valid = 3'b001; release_index[0] = 6'd10;
    cyc(); idle();
    chk_all("t5_flush", 64'h3, 2, 1, 0, 0);

    // Low-water boundary: 3 free is not almost empty
    flush_valid = 1'b1; flush_free_mask = 64'h7;
    cyc(); idle();
    chk_all("lw_three", 64'h7, 3, 0, 0, 0);

    // Raise both errors, then check they survive a flush
    alloc_valid = 3'b001;   alloc_index[0] = 6'd5;
    release_valid = 3'b001; release_index[0] = 6'd1;
    cyc(); idle();
    chk_all("errs_set", 64'h7, 3, 0, 1, 1);
    flush_valid = 1'b1; flush_free_mask = 64'hF0;
    cyc(); idle();
    chk_all("errs_sticky", 64'hF0, 4, 0, 1, 1);

    // T6: reset with alloc/release pending gives exact reset values
    reset = 1'b1;
    alloc_valid = 3'b001;   alloc_index[0] = 6'd32;
    release_valid = 3'b001; release_index[0] = 6'd0;
    cyc(); idle();
    chk_all("t6_reset_mid", 64'hFFFFFFFF_00000000, 32, 0, 0, 0);

    // Drain entries 32..63 three at a time
    for (int b = 32; b < 64; b += 3) begin
      for (int k = 0; k < 3; k++) begin
        if (b + k < 64) begin
          alloc_valid[k] = 1'b1;
          alloc_index[k] = 6'(b + k);
        end
      end
      cyc(); idle();
    end
    chk_all("t6_drained", 64'h0, 0, 1, 0, 0);
    alloc_valid = 3'b001; alloc_index[0] = 6'd63;
    cyc(); idle();
    chk_all("t6_empty_alloc", 64'h0, 0, 1, 0, 1);

    // Full: count 64, further release is a double free
    flush_valid = 1'b1; flush_free_mask = '1;
    cyc(); idle();
    chk_all("full", 64'hFFFFFFFF_FFFFFFFF, 64, 0, 0, 1);
    release_valid = 3'b100; release_index[2] = 6'd17;
    cyc(); idle();
    chk_all("full_rel", 64'hFFFFFFFF_FFFFFFFF, 64, 0, 1, 1);

    // Mixed traffic checked only by the model
    do_reset();
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < 3; k++) begin
        alloc_valid[k]   = ($urandom_range(0, 1) == 1);
        alloc_index[k]   = 6'($urandom_range(0, 63));
        release_valid[k] = ($urandom_range(0, 1) == 1);
        release_index[k] = 6'($urandom_range(0, 63));
      end
      flush_valid     = ($urandom_range(0, 15) == 0);
      flush_free_mask = {$urandom, $urandom};
      reset           = ($urandom_range(0, 31) == 0);
      cyc();
    end
    idle();
    cyc();
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
